// File: rtl/larpix_piso_rx.sv
// Controller-side UART receiver for one LArPix PISO lane, with a single-entry valid/ready holder.
// Define LARPIX_PISO_RX_PARITY_CHECK_EN to drop frames whose WIDTH bits fail odd parity.
module larpix_piso_rx #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                piso,
  output logic [WIDTH-1:0]    packet_out,
  output logic                packet_valid,
  input  logic                packet_ready,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overflow,
  output logic [CNT_BITS-1:0] packet_count,
  output logic                rx_busy
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);
  localparam logic [7:0] FullDiv = 8'(CLK_DIV);
  localparam logic [7:0] HalfDiv = (CLK_DIV / 2 < 1) ? 8'd1 : 8'(CLK_DIV / 2);

  logic [1:0]          sync_q;
  logic                piso_s;
  logic [2:0]          state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic                done_q, done_d;
  logic                frame_err_q, frame_err_d;
  logic [WIDTH-1:0]    pkt_q, pkt_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                expire;
  logic                parity_ok;
  logic                accept;

  assign piso_s = sync_q[1];
  assign expire = (timer_q == 8'd1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!piso_s) begin
          timer_d = HalfDiv;
          state_d = StStart;
        end
      end
      StStart: begin
        if (!expire) begin
          timer_d = timer_q - 8'd1;
        end else if (piso_s) begin
          state_d = StIdle;
        end else begin
          timer_d = FullDiv;
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (!expire) begin
          timer_d = timer_q - 8'd1;
        end else begin
          shift_d[idx_q] = piso_s;
          timer_d        = FullDiv;
          if (idx_q == LastIdx) state_d = StStop;
          else                  idx_d   = idx_q + IdxW'(1);
        end
      end
      StStop: begin
        if (!expire) begin
          timer_d = timer_q - 8'd1;
        end else if (piso_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StBreak;
        end
      end
      StBreak: begin
        // Line must return high before another start bit is accepted.
        if (piso_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef LARPIX_PISO_RX_PARITY_CHECK_EN
  logic parity_err_q;

  assign parity_ok  = ^shift_q;
  assign parity_err = parity_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_err_q <= 1'b0;
    else          parity_err_q <= done_q & ~parity_ok;
  end
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // A same-cycle handshake frees the holder, so a new frame may replace the consumed one.
  always_comb begin
    accept     = done_q & parity_ok & (~valid_q | packet_ready);
    pkt_d      = accept ? shift_q : pkt_q;
    valid_d    = accept ? 1'b1 : (valid_q & ~packet_ready);
    count_d    = count_q + CNT_BITS'(accept);
    overflow_d = overflow_q | (done_q & parity_ok & valid_q & ~packet_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b11;
      state_q     <= StIdle;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      pkt_q       <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      sync_q      <= {sync_q[0], piso};
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      pkt_q       <= pkt_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

  assign packet_out   = pkt_q;
  assign packet_valid = valid_q;
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;
  assign packet_count = count_q;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_larpix_piso_rx.sv
// Self-checking bench for larpix_piso_rx: frame table plus hand-written corner sequences,
// delivered packets checked against a scoreboard queue.
module tb_larpix_piso_rx;

  localparam int unsigned W  = 64;
  localparam int unsigned CD = 4;
  localparam int unsigned CB = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          piso = 1'b1;
  logic          packet_ready = 1'b1;
  logic [W-1:0]  packet_out;
  logic          packet_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overflow;
  logic [CB-1:0] packet_count;
  logic          rx_busy;

  always #5 clk = ~clk;

  larpix_piso_rx #(
    .WIDTH    (W),
    .CLK_DIV  (CD),
    .CNT_BITS (CB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .piso         (piso),
    .packet_out   (packet_out),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overflow     (overflow),
    .packet_count (packet_count),
    .rx_busy      (rx_busy)
  );

  typedef struct {
    logic [63:0] data;
    int          idle_bits;
  } frame_vec_t;

  int          total_cnt = 0;
  int          pass_cnt = 0;
  int          exp_count = 0;
  int          ferr_n = 0;
  int          perr_n = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic delivers(input logic [63:0] d);
`ifdef LARPIX_PISO_RX_PARITY_CHECK_EN
    return ^d;
`else
    return d[0] | ~d[0];
`endif
  endfunction

  task automatic drive_bit(input logic b);
    piso = b;
    repeat (CD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] d, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshake must match the oldest expected packet.
  always @(negedge clk) begin
    if (reset_n && packet_valid && packet_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got %h, expected no packet", packet_out);
      end else begin
        check("sb_packet", packet_out, exp_q.pop_front());
      end
    end
    if (frame_err) ferr_n++;
    if (parity_err) perr_n++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    frame_vec_t  vecs[5];
    int          lat;
    logic        found;
    int          unstable;
    int          base;
    int          done_cyc;
    logic        seen;
    logic [63:0] held;
    logic [63:0] pa, pb, pe;

    vecs[0] = '{64'hA5A5_0000_1234_5678, 0};
    vecs[1] = '{64'h0000_0000_0000_0001, 0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 0};
    vecs[3] = '{64'h8000_0000_0000_0000, 2};
    vecs[4] = '{64'h5555_5555_5555_5554, 1};

    // Reset values
    idle_cycles(3);
    check("rst_packet_out", packet_out, 0);
    check("rst_valid", packet_valid, 0);
    check("rst_count", packet_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy", rx_busy, 0);
    reset_n = 1'b1;
    idle_cycles(5);

    // Single frame: latency and one-cycle valid
    exp_q.push_back(64'hA5A5_0000_1234_5678);
    exp_count++;
    lat = 0;
    found = 1'b0;
    fork
      send_frame(64'hA5A5_0000_1234_5678, 1'b1);
      begin
        @(posedge clk);
        for (int i = 0; i < 400 && !found; i++) begin
          @(posedge clk);
          #1;
          lat++;
          if (packet_valid) found = 1'b1;
        end
      end
    join
    check("t1_latency", lat, 265);
    check("t1_count", packet_count, exp_count);
    idle_cycles(1);
    check("t1_valid_width", packet_valid, 0);
    idle_cycles(5);

    // Frame table: first three back to back, then with idle bits
    for (int v = 0; v < 5; v++) begin
      if (delivers(vecs[v].data)) begin
        exp_q.push_back(vecs[v].data);
        exp_count++;
      end
      send_frame(vecs[v].data, 1'b1);
      for (int g = 0; g < vecs[v].idle_bits; g++) drive_bit(1'b1);
    end
    idle_cycles(10);
    check("t2_count", packet_count, exp_count);
    check("t2_overflow", overflow, 0);
    check("t2_drained", exp_q.size(), 0);

    // Overflow: first held stable, second dropped
    pa = 64'h1111_2222_3333_4440;
    pb = 64'h0F0F_0F0F_0F0F_0F07;
    packet_ready = 1'b0;
    exp_q.push_back(pa);
    exp_count++;
    send_frame(pa, 1'b1);
    idle_cycles(4);
    held = packet_out;
    check("t3_first_held", held, pa);
    unstable = 0;
    fork
      send_frame(pb, 1'b1);
      for (int i = 0; i < 66 * CD + 8; i++) begin
        @(negedge clk);
        if (packet_out !== held || !packet_valid) unstable++;
      end
    join
    idle_cycles(4);
    check("t3_stable", unstable, 0);
    check("t3_overflow", overflow, 1);
    check("t3_count", packet_count, exp_count);
    packet_ready = 1'b1;
    idle_cycles(4);
    check("t3_overflow_sticky", overflow, 1);
    check("t3_valid_after", packet_valid, 0);
    check("t3_drained", exp_q.size(), 0);

    // Framing error, long break, then recovery
    base = ferr_n;
    send_frame(64'h0000_FFFF_0000_FFFE, 1'b0);
    for (int i = 0; i < 20; i++) drive_bit(1'b0);
    piso = 1'b1;
    idle_cycles(8);
    check("t4_frame_err_pulses", ferr_n - base, 1);
    check("t4_no_packet", packet_valid, 0);
    check("t4_count", packet_count, exp_count);
    check("t4_busy", rx_busy, 0);
    pe = 64'hC001_D00D_0000_0007;
    if (delivers(pe)) begin
      exp_q.push_back(pe);
      exp_count++;
    end
    send_frame(pe, 1'b1);
    idle_cycles(6);
    check("t4_recover_count", packet_count, exp_count);
    check("t4_drained", exp_q.size(), 0);

    // Start glitch of one cycle
    base = ferr_n;
    @(posedge clk);
    #1 piso = 1'b0;
    @(posedge clk);
    #1 piso = 1'b1;
    seen = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rx_busy) seen = 1'b1;
      else if (seen && done_cyc < 0) done_cyc = i;
    end
    check("t5_entered_start", seen, 1);
    check("t5_busy_clear", (done_cyc >= 0 && done_cyc <= 4), 1);
    check("t5_no_err", ferr_n - base, 0);
    check("t5_count", packet_count, exp_count);

    // Even-parity packet
    base = perr_n;
`ifdef LARPIX_PISO_RX_PARITY_CHECK_EN
    send_frame(64'h0000_0000_0000_0003, 1'b1);
    idle_cycles(6);
    check("t6_parity_err", perr_n - base, 1);
`else
    exp_q.push_back(64'h0000_0000_0000_0003);
    exp_count++;
    send_frame(64'h0000_0000_0000_0003, 1'b1);
    idle_cycles(6);
    check("t6_parity_err", perr_n - base, 0);
`endif
    check("t6_valid", packet_valid, 0);
    check("t6_count", packet_count, exp_count);
    check("t6_drained", exp_q.size(), 0);

    // Reset asserted during data bit 30
    pe = 64'h0123_4567_89AB_CDEE;
    drive_bit(1'b0);
    for (int i = 0; i < 30; i++) drive_bit(pe[i]);
    piso = pe[30];
    @(posedge clk);
    #1 reset_n = 1'b0;
    piso = 1'b1;
    exp_count = 0;
    #1;
    check("t7_rst_packet_out", packet_out, 0);
    check("t7_rst_valid", packet_valid, 0);
    check("t7_rst_count", packet_count, 0);
    check("t7_rst_overflow", overflow, 0);
    check("t7_rst_busy", rx_busy, 0);
    check("t7_rst_frame_err", frame_err, 0);
    idle_cycles(3);
    reset_n = 1'b1;
    idle_cycles(10);
    check("t7_idle_busy", rx_busy, 0);
    pe = 64'hA5A5_0000_1234_5678;
    exp_q.push_back(pe);
    exp_count++;
    send_frame(pe, 1'b1);
    idle_cycles(6);
    check("t7_count", packet_count, exp_count);
    check("t7_drained", exp_q.size(), 0);
    check("t7_overflow", overflow, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/larpix_piso_rx.md
Name: larpix_piso_rx

Overview:
- Controller-side UART receiver for the LArPix PISO (primary-in-secondary-out) serial line.
- Deserializes start-bit / WIDTH-bit / stop-bit frames sent by the chip on one piso lane.
- Presents each completed packet on a valid/ready interface to the controller's packet buffer.
- Reports framing errors, overflow and packet count; one instance is used per piso lane.

Parameters:
- WIDTH, 64, data bits per frame, excluding start and stop bits.
- CLK_DIV, 4, clk cycles per UART bit; legal values are 2..255.
- CNT_BITS, 16, width of packet_count.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- piso  input  1  serial line from the chip; idles high.
- packet_out  output  WIDTH  received packet, bit 0 = first data bit on the line.
- packet_valid  output  1  packet_out holds an unconsumed packet.
- packet_ready  input  1  consumer accepts packet_out when packet_valid && packet_ready.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on a parity failure (see Optional Feature).
- overflow  output  1  sticky; set when a good packet is dropped; cleared only by reset.
- packet_count  output  CNT_BITS  count of packets accepted into the holding register; wraps.
- rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - packet_out = 0; packet_valid, frame_err, parity_err, overflow, rx_busy = 0; packet_count = 0.
  - The synchronizer flops reset to 1.
- Synchronizer: piso passes through 2 flops; the result is piso_s. All decisions use piso_s.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when piso_s = 0, load bit timer = CLK_DIV/2 (integer division, minimum 1) and go to START.
  - START: count the timer down. At 0, sample piso_s.
    - If 1: glitch; return to IDLE with no error.
    - If 0: reload timer = CLK_DIV, clear bit index, go to DATA.
  - DATA: at each timer expiry, shift piso_s into shift register position [bit index] (LSB first) and reload timer = CLK_DIV. After WIDTH samples, go to STOP.
  - STOP: at timer expiry, sample piso_s.
    - If 1: good frame; return to IDLE.
    - If 0: pulse frame_err, discard the frame, go to BREAK.
  - BREAK: wait until piso_s = 1, then go to IDLE. A new start bit is never detected inside BREAK.
- Back-to-back frames: a start bit arriving on the cycle after the stop-bit sample is detected; the receiver needs zero idle bits between frames.
- Holding register (single entry):
  - Good frame completing at sample cycle k with packet_valid = 0:
    - packet_out is loaded and packet_valid = 1 at cycle k+1.
    - packet_count increments at cycle k+1.
  - Frame completing while packet_valid = 1 and packet_ready = 1 in the same cycle: the handshake consumes the old packet, the new packet is loaded, packet_valid stays 1, and no overflow is flagged.
  - Frame completing while packet_valid = 1 and packet_ready = 0: the new packet is dropped, overflow is set, packet_out is unchanged and packet_count does not increment.
  - Handshake with no new frame: packet_valid = 0 at the next cycle; packet_out holds its last value.
- packet_out is stable while packet_valid = 1 and packet_ready = 0.
- Latency: start edge at the piso pin to packet_valid is 2 + CLK_DIV/2 + (WIDTH+1)·CLK_DIV + 1 cycles. For CLK_DIV = 4 and WIDTH = 64 this is 265 cycles.
- Reset asserted mid-frame:
  - All state clears immediately and the FSM goes to IDLE.
  - After release, the rest of the old frame is treated as line data. An error on that remnant is acceptable. A spurious good packet is acceptable only if the remnant happens to form a valid frame.

Optional Feature:
- Macro: LARPIX_PISO_RX_PARITY_CHECK_EN.
- Defined:
  - Bit WIDTH-1 of each frame is an odd-parity bit over bits WIDTH-1..0.
  - A good-stop frame whose XOR over all WIDTH bits is 0 pulses parity_err at cycle k+1.
  - That frame is discarded: it is not loaded, not counted and does not set overflow.
- Not defined:
  - parity_err is tied to 0.
  - Every good-stop frame is delivered regardless of parity.

Test Plan:
- Single frame, CLK_DIV = 4, packet 64'hA5A5_0000_1234_5678 (odd parity), packet_ready = 1 → packet_out matches, packet_valid high exactly 1 cycle, 265 cycles after the start edge; packet_count = 1.
- Three back-to-back frames with no idle bits, packet_ready = 1 → all three delivered in order; packet_count = 3; overflow = 0.
- packet_ready = 0, two frames → the first is held stable, the second is dropped, overflow = 1 and stays 1 after packet_ready rises; packet_count = 1.
- Stop bit forced to 0 → frame_err pulses 1 cycle; no packet delivered; line held low for 20 bits then released → next good frame is received correctly.
- Start glitch: piso low for 1 cycle (CLK_DIV = 4) → no state change beyond START, no errors, rx_busy returns to 0 within 4 cycles.
- With LARPIX_PISO_RX_PARITY_CHECK_EN, send an even-parity packet 64'h0000_0000_0000_0003 → parity_err pulses; packet_valid stays 0; packet_count unchanged. Without the macro, the same packet is delivered.
- Reset asserted at data bit 30 → all outputs return to reset values; a subsequent good frame is received correctly.
